// File: rtl/tp_pkg.sv
// tp_pkg: opcode, ALU unit-select and execute-state definitions shared across the tiny processor
package tp_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_NAND, OP_SHL, OP_SHR, OP_LD, OP_OR,
    OP_XOR, OP_ST, OP_LDI, OP_BNEZ, OP_NOP0, OP_NOP1, OP_NOP2, OP_HALT
  } opcode_t;
  localparam logic [2:0] UNIT_ADD      = 3'b000;
  localparam logic [2:0] UNIT_AND      = 3'b001;
  localparam logic [2:0] UNIT_SHIFT    = 3'b010;
  localparam logic [2:0] UNIT_PASS_SRC = 3'b011;
  localparam logic [2:0] UNIT_OR       = 3'b100;
  localparam logic [2:0] UNIT_XOR      = 3'b101;
  localparam logic [2:0] UNIT_PASS_ACC = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;
  function automatic logic [2:0] unit_of(opcode_t o);
    case (o)
      OP_ADD, OP_SUB:  return UNIT_ADD;
      OP_AND, OP_NAND: return UNIT_AND;
      OP_SHL, OP_SHR:  return UNIT_SHIFT;
      OP_LD, OP_LDI:   return UNIT_PASS_SRC;
      OP_OR:           return UNIT_OR;
      OP_XOR:          return UNIT_XOR;
      default:         return UNIT_PASS_ACC;
    endcase
  endfunction
endpackage

// File: rtl/reg_file_8x8.sv
// reg_file_8x8: eight 8-bit registers, combinational read, synchronous write and reset
module reg_file_8x8 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] regs [8];
  assign rdata = regs[addr];
  // clear everything on reset, otherwise write the addressed register
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 8; i++)
      regs[i] <= rst_in ? 8'h00 : (we && addr == 3'(i)) ? wdata : regs[i];
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage owning acc, register file and pc; drives the ALU and commits its result
module exec_unit
  import tp_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] instr_in,
  input  logic       instr_valid_in,
  output logic       instr_ready_out,
  output logic [7:0] pc_out,
  output logic [2:0] alu_unit_sel_out,
  output logic       alu_op_sel_out,
  output logic [7:0] alu_acc_out,
  output logic [7:0] alu_src_out,
  input  logic [7:0] alu_res_in,
  output logic [7:0] acc_out,
  output logic       retire_out,
  output logic       halted_out
);
  state_t     state;
  logic [7:0] instr_q, pc, acc, rd_data;
  opcode_t    opc;
  logic [3:0] imm;
  logic       exec, reg_op, writes_acc, taken;
  assign opc        = opcode_t'(instr_q[7:4]);
  assign imm        = instr_q[3:0];
  assign exec       = state == EXEC;
  assign reg_op     = opc <= OP_XOR;
  assign writes_acc = reg_op || opc == OP_LDI;
  assign taken      = opc == OP_BNEZ && alu_res_in != 8'h00;
  reg_file_8x8 u_rf (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .we     (exec && opc == OP_ST),
    .addr   (instr_q[2:0]),
    .wdata  (alu_res_in),
    .rdata  (rd_data)
  );
  // ALU drives decode only in EXEC; otherwise the ALU just passes acc
  always_comb begin
    alu_unit_sel_out = exec ? unit_of(opc) : UNIT_PASS_ACC;
    alu_op_sel_out   = exec && (opc == OP_SUB || opc == OP_NAND || opc == OP_SHR);
    alu_src_out      = !exec ? 8'h00 : reg_op ? rd_data : opc == OP_LDI ? {acc[3:0], imm} : 8'h00;
  end
  assign alu_acc_out     = acc;
  assign acc_out         = acc;
  assign pc_out          = pc;
  assign instr_ready_out = state == IDLE && !rst_in;
  // handshake in IDLE, commit acc/pc and pulse retire at the end of EXEC, HALT is sticky
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      instr_q    <= 8'hC0;
      pc         <= 8'h00;
      acc        <= 8'h00;
      retire_out <= 1'b0;
      halted_out <= 1'b0;
    end else begin
      retire_out <= 1'b0;
      case (state)
        IDLE: if (instr_valid_in) begin
          instr_q <= instr_in;
          state   <= EXEC;
        end
        EXEC: begin
          retire_out <= 1'b1;
          state      <= opc == OP_HALT ? HALT : IDLE;
          halted_out <= opc == OP_HALT;
          acc        <= writes_acc ? alu_res_in : acc;
          pc         <= opc == OP_HALT ? pc : taken ? pc + {{4{imm[3]}}, imm} : pc + 8'h01;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: table-driven program run against a behavioural ALU with a retire scoreboard
module tb_exec_unit;
  logic       clk_in = 1'b0, rst_in = 1'b1, instr_valid_in = 1'b0;
  logic [7:0] instr_in = 8'h00;
  logic       instr_ready_out, alu_op_sel_out, retire_out, halted_out;
  logic [7:0] pc_out, alu_acc_out, alu_src_out, alu_res_in, acc_out;
  logic [2:0] alu_unit_sel_out;
  typedef struct { logic [7:0] instr, acc, pc; } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0, failures = 0, retires = 0, issued = 0;
  exec_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
    .instr_ready_out(instr_ready_out), .pc_out(pc_out), .alu_unit_sel_out(alu_unit_sel_out),
    .alu_op_sel_out(alu_op_sel_out), .alu_acc_out(alu_acc_out), .alu_src_out(alu_src_out),
    .alu_res_in(alu_res_in), .acc_out(acc_out), .retire_out(retire_out), .halted_out(halted_out)
  );
  always #5 clk_in = ~clk_in;
  // behavioural ALU
  always_comb begin
    case (alu_unit_sel_out)
      3'b000:  alu_res_in = alu_op_sel_out ? alu_acc_out - alu_src_out : alu_acc_out + alu_src_out;
      3'b001:  alu_res_in = alu_op_sel_out ? ~(alu_acc_out & alu_src_out) : alu_acc_out & alu_src_out;
      3'b010:  alu_res_in = alu_op_sel_out ? alu_acc_out >> alu_src_out[2:0] : alu_acc_out << alu_src_out[2:0];
      3'b011:  alu_res_in = alu_src_out;
      3'b100:  alu_res_in = alu_acc_out | alu_src_out;
      3'b101:  alu_res_in = alu_acc_out ^ alu_src_out;
      default: alu_res_in = alu_acc_out;
    endcase
  end
  always @(negedge clk_in) if (retire_out === 1'b1) retires++;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(logic [7:0] i, logic [7:0] a, logic [7:0] p);
    vecs.push_back('{i, a, p});
  endtask
  task automatic issue(vec_t v);
    int n;
    vec_t e;
    n = 0;
    while (instr_ready_out !== 1'b1 && n < 20) begin @(negedge clk_in); n++; end
    if (instr_ready_out !== 1'b1) begin chk("ready_timeout", instr_ready_out, 1); return; end
    instr_in = v.instr;
    instr_valid_in = 1'b1;
    sb.push_back(v);
    issued++;
    @(negedge clk_in);
    instr_valid_in = 1'b0;
    instr_in = 8'($urandom);
    chk("ready_in_exec", instr_ready_out, 0);
    chk("retire_low_in_exec", retire_out, 0);
    n = 0;
    while (retire_out !== 1'b1 && n < 10) begin @(negedge clk_in); n++; end
    chk("retire_pulse", retire_out, 1);
    if (retire_out === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("acc[%h]", e.instr), acc_out, e.acc);
      chk($sformatf("pc[%h]", e.instr), pc_out, e.pc);
    end
  endtask
  task automatic chk_reset_state();
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_retire", retire_out, 0);
    chk("rst_halted", halted_out, 0);
    chk("rst_ready", instr_ready_out, 1);
    chk("rst_unit", alu_unit_sel_out, 3'b111);
    chk("rst_src", alu_src_out, 8'h00);
  endtask
  initial begin
    add(8'hA5,8'h05,8'h01); add(8'h91,8'h05,8'h02); add(8'hA0,8'h50,8'h03); add(8'hA3,8'h03,8'h04);
    add(8'h01,8'h08,8'h05); add(8'hBE,8'h08,8'h03); add(8'hA0,8'h80,8'h04); add(8'hA0,8'h00,8'h05);
    add(8'hBE,8'h00,8'h06); add(8'hA2,8'h02,8'h07); add(8'hA0,8'h20,8'h08); add(8'h92,8'h20,8'h09);
    add(8'hA1,8'h01,8'h0A); add(8'hA0,8'h10,8'h0B); add(8'h12,8'hF0,8'h0C); add(8'hAF,8'h0F,8'h0D);
    add(8'hAF,8'hFF,8'h0E); add(8'h93,8'hFF,8'h0F); add(8'hA0,8'hF0,8'h10); add(8'hAF,8'h0F,8'h11);
    add(8'h33,8'hF0,8'h12); add(8'hA0,8'h00,8'h13); add(8'hA1,8'h01,8'h14); add(8'h93,8'h01,8'h15);
    add(8'hA8,8'h18,8'h16); add(8'hA1,8'h81,8'h17); add(8'h53,8'h40,8'h18); add(8'hA8,8'h08,8'h19);
    add(8'hA1,8'h81,8'h1A); add(8'h43,8'h02,8'h1B); add(8'h94,8'h02,8'h1C); add(8'hA7,8'h27,8'h1D);
    add(8'h64,8'h02,8'h1E); add(8'h72,8'h22,8'h1F); add(8'h81,8'h27,8'h20); add(8'h23,8'h01,8'h21);
    add(8'hC0,8'h01,8'h22); add(8'hE5,8'h01,8'h23); add(8'h09,8'h06,8'h24); add(8'hB8,8'h06,8'h1C);
    add(8'hB8,8'h06,8'h14); add(8'hB8,8'h06,8'h0C); add(8'hB8,8'h06,8'h04); add(8'hB8,8'h06,8'hFC);
    add(8'hC0,8'h06,8'hFD); add(8'hD0,8'h06,8'hFE); add(8'hC0,8'h06,8'hFF); add(8'hB1,8'h06,8'h00);
    for (int i = 1; i <= 7; i++) add(8'hC0, 8'h06, 8'(i));
    add(8'hF0,8'h06,8'h07);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("ready_during_reset", instr_ready_out, 0);
    rst_in = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk_in);
    foreach (vecs[i]) issue(vecs[i]);
    chk("halted", halted_out, 1);
    for (int i = 0; i < 5; i++) begin
      instr_valid_in = 1'b1;
      instr_in = 8'h01;
      @(negedge clk_in);
      chk("halt_ready", instr_ready_out, 0);
      chk("halt_retire", retire_out, 0);
      chk("halt_pc", pc_out, 8'h07);
      chk("halt_acc", acc_out, 8'h06);
      chk("halt_halted", halted_out, 1);
      chk("halt_unit", alu_unit_sel_out, 3'b111);
      chk("halt_src", alu_src_out, 8'h00);
    end
    instr_valid_in = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("ready_in_reset_cycle", instr_ready_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk_reset_state();
    issue('{8'h61, 8'h00, 8'h01});
    while (instr_ready_out !== 1'b1) @(negedge clk_in);
    instr_in = 8'hA5;
    instr_valid_in = 1'b1;
    @(negedge clk_in);
    instr_valid_in = 1'b0;
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("abort_acc", acc_out, 8'h00);
    chk("abort_pc", pc_out, 8'h00);
    chk("abort_retire", retire_out, 0);
    @(negedge clk_in);
    chk("abort_retire_late", retire_out, 0);
    chk("abort_acc_late", acc_out, 8'h00);
    chk("retire_count", retires, issued);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
